alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single shared
// combinational ALU. At most one operation is in flight: a request is
// accepted in IDLE, its operands drive the ALU during EXEC, and the captured
// result is offered to the owning requester in RESP.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   clk_en                    state advances / handshakes complete only when high
//   reqN_valid/ready          request handshake per requester (N = 0, 1)
//   reqN_op/a/b               operation code and operands per requester
//   rspN_valid/ready          response handshake per requester
//   rsp_res/carry/zero        shared response payload (valid with a rspN_valid)
//   alu_op/a/b                drive the external ALU (zero outside EXEC)
//   alu_res/carry/zero        ALU results, same cycle
module alu_arbiter #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [2:0] req0_op,
    input  logic [2:0] req1_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req1_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_b,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    input  logic       rsp0_ready,
    input  logic       rsp1_ready,
    output logic [7:0] rsp_res,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_res,
    input  logic       alu_carry,
    input  logic       alu_zero
);

    localparam logic RrInitBit = RR_INIT[0];

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_t;

    state_t     r_state, w_state_next;
    logic       r_prio, w_prio_next;    // id of the requester that wins a tie
    logic       r_owner, w_owner_next;  // id of the requester in flight
    logic [2:0] r_op, w_op_next;
    logic [7:0] r_a, w_a_next;
    logic [7:0] r_b, w_b_next;
    logic [7:0] r_res, w_res_next;
    logic       r_carry, w_carry_next;
    logic       r_zero, w_zero_next;

    logic       w_grant0;
    logic       w_grant1;
    logic       w_owner_rsp_ready;

    // A lone valid requester wins; on contention the priority holder wins.
    assign w_grant0 = req0_valid & (~req1_valid | ~r_prio);
    assign w_grant1 = req1_valid & (~req0_valid | r_prio);

    // Readies are masked during reset so nothing looks accepted while rst is high.
    assign req0_ready = (r_state == StIdle) & w_grant0 & ~rst;
    assign req1_ready = (r_state == StIdle) & w_grant1 & ~rst;

    assign rsp0_valid = (r_state == StResp) & ~r_owner;
    assign rsp1_valid = (r_state == StResp) & r_owner;
    assign rsp_res    = r_res;
    assign rsp_carry  = r_carry;
    assign rsp_zero   = r_zero;

    assign alu_op = (r_state == StExec) ? r_op : 3'd0;
    assign alu_a  = (r_state == StExec) ? r_a  : 8'd0;
    assign alu_b  = (r_state == StExec) ? r_b  : 8'd0;

    // The non-owner's ready is never looked at.
    assign w_owner_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio;
        w_owner_next = r_owner;
        w_op_next    = r_op;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_res_next   = r_res;
        w_carry_next = r_carry;
        w_zero_next  = r_zero;
        unique case (r_state)
            StIdle: begin
                if (clk_en && (req0_ready || req1_ready)) begin
                    w_state_next = StExec;
                    w_owner_next = req1_ready;
                    w_op_next    = req1_ready ? req1_op : req0_op;
                    w_a_next     = req1_ready ? req1_a  : req0_a;
                    w_b_next     = req1_ready ? req1_b  : req0_b;
                    // Round-robin: priority moves to the requester not just served.
                    w_prio_next  = ~req1_ready;
                end
            end
            StExec: begin
                if (clk_en) begin
                    w_state_next = StResp;
                    w_res_next   = alu_res;
                    w_carry_next = alu_carry;
                    w_zero_next  = alu_zero;
                end
            end
            StResp: begin
                if (clk_en && w_owner_rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_prio  <= RrInitBit;
            r_owner <= 1'b0;
            r_op    <= 3'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_res   <= 8'd0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_prio  <= w_prio_next;
            r_owner <= w_owner_next;
            r_op    <= w_op_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_res   <= w_res_next;
            r_carry <= w_carry_next;
            r_zero  <= w_zero_next;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Supplies a behavioural
// ALU, runs directed scenarios followed by randomized traffic, and compares
// every output each cycle against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int unsigned RrInit = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req1_a, req0_b, req1_b;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [7:0] rsp_res;
    logic       rsp_carry, rsp_zero;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_res;
    logic       alu_carry, alu_zero;
    logic [9:0] w_alu;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_INIT(RrInit)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .req0_valid(req0_valid),
        .req1_valid(req1_valid),
        .req0_ready(req0_ready),
        .req1_ready(req1_ready),
        .req0_op   (req0_op),
        .req1_op   (req1_op),
        .req0_a    (req0_a),
        .req1_a    (req1_a),
        .req0_b    (req0_b),
        .req1_b    (req1_b),
        .rsp0_valid(rsp0_valid),
        .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready),
        .rsp1_ready(rsp1_ready),
        .rsp_res   (rsp_res),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_res   (alu_res),
        .alu_carry (alu_carry),
        .alu_zero  (alu_zero)
    );

    // Reference ALU: returns {carry, zero, res[7:0]}. Subtract reports borrow as carry.
    function automatic logic [9:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] t;
        case (op)
            3'd0:    t = {1'b0, a} + {1'b0, b};
            3'd1:    t = {1'b0, a} - {1'b0, b};
            3'd2:    t = {1'b0, a & b};
            3'd3:    t = {1'b0, a | b};
            3'd4:    t = {1'b0, a ^ b};
            3'd5:    t = {a, 1'b0};
            3'd6:    t = {a[0], 1'b0, a[7:1]};
            default: t = {1'b0, a};
        endcase
        return {t[8], (t[7:0] == 8'd0), t[7:0]};
    endfunction

    always_comb w_alu = alu_ref(alu_op, alu_a, alu_b);
    assign alu_res   = w_alu[7:0];
    assign alu_zero  = w_alu[8];
    assign alu_carry = w_alu[9];

    // Transaction-level model: at most one operation outstanding; it spends one
    // enabled edge executing, then waits for its owner's response handshake.
    logic       m_busy, m_resp, m_owner, m_prio;
    logic [2:0] m_op;
    logic [7:0] m_a, m_b;
    logic       e_r0, e_r1;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_resp  = 1'b0;
        m_owner = 1'b0;
        m_prio  = 1'(RrInit);
        m_op    = 3'd0;
        m_a     = 8'd0;
        m_b     = 8'd0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [9:0] p;
        logic       exec;
        e_r0 = !rst && !m_busy && req0_valid && (!req1_valid || !m_prio);
        e_r1 = !rst && !m_busy && req1_valid && (!req0_valid || m_prio);
        exec = m_busy && !m_resp;
        check("req0_ready", 32'(req0_ready), 32'(e_r0));
        check("req1_ready", 32'(req1_ready), 32'(e_r1));
        check("alu_op", 32'(alu_op), exec ? 32'(m_op) : 32'd0);
        check("alu_a", 32'(alu_a), exec ? 32'(m_a) : 32'd0);
        check("alu_b", 32'(alu_b), exec ? 32'(m_b) : 32'd0);
        check("rsp0_valid", 32'(rsp0_valid), 32'(m_busy && m_resp && !m_owner));
        check("rsp1_valid", 32'(rsp1_valid), 32'(m_busy && m_resp && m_owner));
        if (m_busy && m_resp) begin
            p = alu_ref(m_op, m_a, m_b);
            check("rsp_res", 32'(rsp_res), 32'(p[7:0]));
            check("rsp_zero", 32'(rsp_zero), 32'(p[8]));
            check("rsp_carry", 32'(rsp_carry), 32'(p[9]));
        end
        if (rst) begin
            check("rst_res", 32'(rsp_res), 32'd0);
            check("rst_flags", 32'({rsp_carry, rsp_zero}), 32'd0);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (clk_en) begin
            if (!m_busy) begin
                if (e_r0 || e_r1) begin
                    m_busy  = 1'b1;
                    m_resp  = 1'b0;
                    m_owner = e_r1;
                    m_op    = e_r1 ? req1_op : req0_op;
                    m_a     = e_r1 ? req1_a  : req0_a;
                    m_b     = e_r1 ? req1_b  : req0_b;
                    m_prio  = ~m_owner;
                end
            end else if (!m_resp) begin
                m_resp = 1'b1;
            end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_busy = 1'b0;
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model, resume 1 after rise.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        clk_en     = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_op = 3'd0; req0_a = 8'd0; req0_b = 8'd0;
        req1_op = 3'd0; req1_a = 8'd0; req1_b = 8'd0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        model_reset();

        // Reset values while rst is held with both requesters valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
        check("rst_payload", 32'({rsp_carry, rsp_zero, rsp_res}), 32'd0);
        rst = 1'b0;

        // Single add from req0: ready in cycle 0, response in cycle 2.
        req1_valid = 1'b0;
        req0_op = 3'd0; req0_a = 8'd2; req0_b = 8'd5;
        #1 check("add_ready0", 32'(req0_ready), 32'd1);
        cycle();
        req0_valid = 1'b0;
        cycle();
        #1 check("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("add_res", 32'(rsp_res), 32'd7);
        check("add_flags", 32'({rsp_carry, rsp_zero}), 32'd0);
        cycle();

        // Contention from reset: req0 first, then req1, then req0 again.
        rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'd10; req0_b = 8'd5;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'd2;  req1_b = 8'd5;
        #1 check("rr1_ready0", 32'(req0_ready), 32'd1);
        check("rr1_ready1", 32'(req1_ready), 32'd0);
        cycle();
        cycle();
        #1 check("rr1_res", 32'(rsp_res), 32'd5);
        cycle();
        #1 check("rr2_ready1", 32'(req1_ready), 32'd1);
        check("rr2_ready0", 32'(req0_ready), 32'd0);
        cycle();
        cycle();
        #1 check("rr2_res", 32'(rsp_res), 32'd7);
        cycle();
        #1 check("rr3_ready0", 32'(req0_ready), 32'd1);
        repeat (3) cycle();

        // req1 response stalled for 5 cycles while req0 keeps asking.
        rsp1_ready = 1'b0;
        req1_op = 3'd3; req1_a = 8'hA0; req1_b = 8'h05;
        #1 check("stall_ready1", 32'(req1_ready), 32'd1);
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            #1 check("stall_rsp1_valid", 32'(rsp1_valid), 32'd1);
            check("stall_res", 32'(rsp_res), 32'hA5);
            check("stall_ready0", 32'(req0_ready), 32'd0);
            cycle();
        end
        rsp1_ready = 1'b1;
        cycle();
        #1 check("stall_done", 32'(rsp1_valid), 32'd0);

        // clk_en low for 3 cycles during EXEC.
        req1_valid = 1'b0;
        req0_op = 3'd4; req0_a = 8'h3C; req0_b = 8'h0F;
        cycle();
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_alu", 32'({alu_op, alu_a, alu_b}), 32'h43C0F);
            check("hold_rsp0", 32'(rsp0_valid), 32'd0);
            cycle();
        end
        clk_en = 1'b1;
        cycle();
        #1 check("hold_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("hold_res", 32'(rsp_res), 32'h33);
        cycle();

        // Reset in the middle of a pending req1 response.
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'd200; req1_b = 8'd100;
        rsp1_ready = 1'b0;
        cycle();
        cycle();
        #1 check("mid_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("mid_carry", 32'(rsp_carry), 32'd1);
        rst = 1'b1;
        model_reset();
        #1 check("mid_rst_valid", 32'(rsp1_valid), 32'd0);
        check("mid_rst_res", 32'(rsp_res), 32'd0);
        cycle();
        rst = 1'b0;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 8'hF0; req0_b = 8'h3C;
        #1 check("post_rst_ready0", 32'(req0_ready), 32'd1);
        check("post_rst_ready1", 32'(req1_ready), 32'd0);
        repeat (3) cycle();

        // Zero result reported to the owner.
        req1_valid = 1'b0;
        req0_op = 3'd1; req0_a = 8'd5; req0_b = 8'd5;
        cycle();
        cycle();
        #1 check("zero_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("zero_res", 32'(rsp_res), 32'd0);
        check("zero_flag", 32'(rsp_zero), 32'd1);
        cycle();

        // Randomized traffic with occasional reset and clock-enable gaps.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (rst) model_reset();
            clk_en     = ($urandom_range(0, 3) != 0);
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
            rsp0_ready = 1'($urandom);
            rsp1_ready = 1'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
